sdram_arbiter: RTL and testbench

Shares the single SDRAM controller port between three byte-wide requesters: PRG fetch (CPU side), CHR fetch/write (PPU side) and the MCU loader's auxiliary channel. It sits between the PRG/CHR RAM front-ends behind the mapper mux and the SDRAM controller. It serialises one transaction at a time, with fixed priority and an aging override for the loader. A pause input lets the mapper-switch logic drain the port.

---
 rtl/sdram_arb_pkg.sv | 43 ++++
 rtl/sdram_arb_pick.sv | 31 +++
 rtl/sdram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the three-way SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CNT_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_PRG = 2'd0,
    REQ_CHR = 2'd1,
    REQ_AUX = 2'd2
  } req_idx_e;

  // Convert a one-hot grant vector to a requester index (prg when empty).
  function automatic req_idx_e onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_e idx;
    idx = REQ_PRG;
    if (oh[2]) begin
      idx = REQ_AUX;
    end else if (oh[1]) begin
      idx = REQ_CHR;
    end
    return idx;
  endfunction

  // Convert a requester index to its one-hot bit.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_e idx);
    logic [NUM_REQ-1:0] oh;
    case (idx)
      REQ_CHR: oh = 3'b010;
      REQ_AUX: oh = 3'b100;
      default: oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner select: fixed priority prg > chr > aux, with the
// starved aux channel taking precedence when promoted.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               starve,
  output logic [NUM_REQ-1:0] grant_c,
  output logic               valid_c
);

  logic [NUM_REQ-1:0] live_c;

  // Drop masked requesters, then resolve by promotion and priority.
  always_comb begin
    live_c  = req & ~mask;
    grant_c = '0;
    if (starve && live_c[2]) begin
      grant_c = 3'b100;
    end else if (live_c[0]) begin
      grant_c = 3'b001;
    end else if (live_c[1]) begin
      grant_c = 3'b010;
    end else if (live_c[2]) begin
      grant_c = 3'b100;
    end
    valid_c = |live_c;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Serialises prg, chr and aux byte accesses onto the single SDRAM
// controller port, one transaction at a time.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 23,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prg_req,
  input  logic [ADDR_BITS-1:0] prg_addr,
  output logic                 prg_ack,
  input  logic                 chr_req,
  input  logic [ADDR_BITS-1:0] chr_addr,
  input  logic                 chr_we,
  input  logic [DATA_BITS-1:0] chr_wdata,
  output logic                 chr_ack,
  input  logic                 aux_req,
  input  logic [ADDR_BITS-1:0] aux_addr,
  input  logic                 aux_we,
  input  logic [DATA_BITS-1:0] aux_wdata,
  output logic                 aux_ack,
  output logic [DATA_BITS-1:0] rdata,
  input  logic                 pause,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam logic [CNT_BITS-1:0] STARVE_MAX = CNT_BITS'(STARVE_LIMIT);

  arb_state_e          state;
  req_idx_e            winner;
  logic [NUM_REQ-1:0]  mask;
  logic [CNT_BITS-1:0] starve_cnt;

  logic [NUM_REQ-1:0]  req_vec_c;
  logic                starve_full_c;
  logic [NUM_REQ-1:0]  grant_c;
  logic                grant_valid_c;
  req_idx_e            pick_idx_c;

  // Gather request levels and the aux promotion flag for the picker.
  always_comb begin
    req_vec_c     = {aux_req, chr_req, prg_req};
    starve_full_c = (starve_cnt == STARVE_MAX);
    pick_idx_c    = onehot_to_idx(grant_c);
  end

  sdram_arb_pick u_pick (
    .req     (req_vec_c),
    .mask    (mask),
    .starve  (starve_full_c),
    .grant_c (grant_c),
    .valid_c (grant_valid_c)
  );

  // Arbitration FSM with registered command fields, acks and aging counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      winner     <= REQ_PRG;
      mask       <= '0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      prg_ack    <= 1'b0;
      chr_ack    <= 1'b0;
      aux_ack    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      prg_ack <= 1'b0;
      chr_ack <= 1'b0;
      aux_ack <= 1'b0;

      case (state)
        IDLE: begin
          // The served-requester mask only covers the first idle cycle.
          mask <= '0;
          if (!aux_req) begin
            starve_cnt <= '0;
          end
          if (!pause && grant_valid_c) begin
            winner  <= pick_idx_c;
            state   <= ISSUE;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            unique case (pick_idx_c)
              REQ_CHR: begin
                mem_addr  <= chr_addr;
                mem_we    <= chr_we;
                mem_wdata <= chr_wdata;
              end
              REQ_AUX: begin
                mem_addr  <= aux_addr;
                mem_we    <= aux_we;
                mem_wdata <= aux_wdata;
              end
              default: begin
                mem_addr  <= prg_addr;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
              end
            endcase
            if (pick_idx_c == REQ_AUX) begin
              starve_cnt <= '0;
            end else if (aux_req && (starve_cnt < STARVE_MAX)) begin
              starve_cnt <= starve_cnt + CNT_BITS'(1);
            end
          end
        end

        ISSUE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata   <= mem_rdata;
            state   <= DONE;
            case (winner)
              REQ_CHR: chr_ack <= 1'b1;
              REQ_AUX: aux_ack <= 1'b1;
              default: prg_ack <= 1'b1;
            endcase
          end
        end

        DONE: begin
          busy  <= 1'b0;
          mask  <= idx_to_onehot(winner);
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: three requester agents, an SDRAM
// controller stand-in, and a cycle-level reference model of the arbitration rules.
module tb_sdram_arbiter;

  localparam int unsigned AW    = 23;
  localparam int          LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          prg_req, chr_req, aux_req;
  logic [AW-1:0] prg_addr, chr_addr, aux_addr;
  logic          chr_we, aux_we;
  logic [7:0]    chr_wdata, aux_wdata;
  logic          prg_ack, chr_ack, aux_ack;
  logic [7:0]    rdata;
  logic          pause;
  logic          busy;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  int checks;
  int failures;

  sdram_arbiter #(.ADDR_BITS(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .prg_req(prg_req), .prg_addr(prg_addr), .prg_ack(prg_ack),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_we(chr_we), .chr_wdata(chr_wdata), .chr_ack(chr_ack),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_we(aux_we), .aux_wdata(aux_wdata), .aux_ack(aux_ack),
    .rdata(rdata), .pause(pause), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- requester agents ----------------
  logic          r_req [3];
  logic [AW-1:0] r_addr[3];
  logic          r_we  [3];
  logic [7:0]    r_wd  [3];
  int            want[3], gap[3], hold_cnt[3], hold_next[3], acks_seen[3];
  bit            drop_pending[3];
  bit            use_fix[3];
  logic [AW-1:0] fix_addr[3];
  logic          fix_we[3];
  logic [7:0]    fix_wd[3];
  int            gap_max;
  logic [2:0]    ack_vec;

  assign prg_req = r_req[0];  assign prg_addr = r_addr[0];
  assign chr_req = r_req[1];  assign chr_addr = r_addr[1];
  assign aux_req = r_req[2];  assign aux_addr = r_addr[2];
  assign chr_we = r_we[1];    assign chr_wdata = r_wd[1];
  assign aux_we = r_we[2];    assign aux_wdata = r_wd[2];
  assign ack_vec = {aux_ack, chr_ack, prg_ack};

  initial begin
    for (int i = 0; i < 3; i++) begin
      r_req[i] = 1'b0; r_addr[i] = '0; r_we[i] = 1'b0; r_wd[i] = '0;
      gap[i] = 0; hold_cnt[i] = 0; acks_seen[i] = 0; drop_pending[i] = 1'b0;
    end
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          r_req[i] = 1'b0;
          drop_pending[i] = 1'b0;
        end else if (drop_pending[i]) begin
          if (hold_cnt[i] > 0) hold_cnt[i]--;
          else begin
            r_req[i] = 1'b0;
            drop_pending[i] = 1'b0;
            gap[i] = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
          end
        end else if (r_req[i]) begin
          if (ack_vec[i]) begin
            drop_pending[i] = 1'b1;
            acks_seen[i]++;
          end
        end else if (want[i] > 0) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            r_req[i] = 1'b1;
            want[i]--;
            hold_cnt[i] = hold_next[i];
            hold_next[i] = 0;
            if (use_fix[i]) begin
              r_addr[i] = fix_addr[i]; r_we[i] = fix_we[i]; r_wd[i] = fix_wd[i];
            end else begin
              r_addr[i] = AW'($urandom);
              r_we[i]   = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
              r_wd[i]   = 8'($urandom);
            end
          end
        end
      end
    end
  end

  // ---------------- SDRAM controller stand-in ----------------
  int mem_lat;
  int fix_rdata;
  bit spur_en;

  initial begin
    int dly;
    bit pend;
    mem_ack = 1'b0; mem_rdata = '0; pend = 1'b0; dly = 0;
    forever begin
      @(posedge clk); #3;
      if (reset) begin
        mem_ack = 1'b0; pend = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!pend) begin
          pend = 1'b1;
          dly = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
        if (dly == 0) begin
          mem_ack = 1'b1;
          mem_rdata = (fix_rdata >= 0) ? 8'(fix_rdata) : 8'($urandom);
          pend = 1'b0;
        end else dly--;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  typedef enum {PH_FREE, PH_FLIGHT, PH_ACK} ph_e;
  int grant_log[$];

  initial begin
    ph_e           ph;
    int            win, mask_id, starve, w;
    bit            c0, c1, c2, promote;
    logic [7:0]    exp_rdata;
    logic [AW-1:0] cur_addr;
    logic          p_reset, p_pause, p_mem_ack;
    logic [7:0]    p_mem_rdata;
    logic          p_req[3];
    logic [AW-1:0] p_addr[3];
    logic          p_we[3];
    logic [7:0]    p_wd[3];
    logic [2:0]    act_ack;
    ph = PH_FREE; win = 0; mask_id = -1; starve = 0; exp_rdata = '0; cur_addr = '0;
    p_reset = 1'b1; p_pause = 1'b0; p_mem_ack = 1'b0; p_mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      p_req[i] = 1'b0; p_addr[i] = '0; p_we[i] = 1'b0; p_wd[i] = '0;
    end
    forever begin
      @(negedge clk);
      act_ack = {aux_ack, chr_ack, prg_ack};
      if (p_reset) begin
        check_eq("rst_mem_req", 32'(mem_req), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_acks", 32'(act_ack), 0);
        check_eq("rst_rdata", 32'(rdata), 0);
        check_eq("rst_mem_cmd", 32'({mem_we, mem_wdata}), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        ph = PH_FREE; mask_id = -1; starve = 0; exp_rdata = '0;
      end else begin
        case (ph)
          PH_FREE: begin
            c0 = p_req[0] && (mask_id != 0);
            c1 = p_req[1] && (mask_id != 1);
            c2 = p_req[2] && (mask_id != 2);
            promote = c2 && (starve >= LIMIT);
            mask_id = -1;
            if (!p_req[2]) starve = 0;
            check_eq("idle_acks", 32'(act_ack), 0);
            check_eq("idle_rdata_hold", 32'(rdata), 32'(exp_rdata));
            if (!p_pause && (c0 || c1 || c2)) begin
              w = promote ? 2 : (c0 ? 0 : (c1 ? 1 : 2));
              check_eq("grant_mem_req", 32'(mem_req), 1);
              check_eq("grant_busy", 32'(busy), 1);
              check_eq("grant_addr", 32'(mem_addr), 32'(p_addr[w]));
              check_eq("grant_we", 32'(mem_we), (w == 0) ? 0 : 32'(p_we[w]));
              check_eq("grant_wdata", 32'(mem_wdata), (w == 0) ? 0 : 32'(p_wd[w]));
              if (w == 2) starve = 0;
              else if (p_req[2] && starve < LIMIT) starve++;
              grant_log.push_back(w);
              win = w; cur_addr = p_addr[w]; ph = PH_FLIGHT;
            end else begin
              check_eq("idle_mem_req", 32'(mem_req), 0);
              check_eq("idle_busy", 32'(busy), 0);
            end
          end
          PH_FLIGHT: begin
            check_eq("flight_busy", 32'(busy), 1);
            if (p_mem_ack) begin
              check_eq("done_ack", 32'(act_ack), 32'(1 << win));
              check_eq("done_rdata", 32'(rdata), 32'(p_mem_rdata));
              check_eq("done_mem_req", 32'(mem_req), 0);
              exp_rdata = p_mem_rdata;
              ph = PH_ACK;
            end else begin
              check_eq("flight_mem_req", 32'(mem_req), 1);
              check_eq("flight_addr", 32'(mem_addr), 32'(cur_addr));
              check_eq("flight_acks", 32'(act_ack), 0);
            end
          end
          default: begin
            check_eq("post_acks", 32'(act_ack), 0);
            check_eq("post_busy", 32'(busy), 0);
            check_eq("post_mem_req", 32'(mem_req), 0);
            mask_id = win;
            ph = PH_FREE;
          end
        endcase
      end
      p_reset = reset; p_pause = pause; p_mem_ack = mem_ack; p_mem_rdata = mem_rdata;
      for (int i = 0; i < 3; i++) begin
        p_req[i] = r_req[i]; p_addr[i] = r_addr[i]; p_we[i] = r_we[i]; p_wd[i] = r_wd[i];
      end
    end
  end

  // ---------------- directed and random sequences ----------------
  int base[3];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic snap_base();
    for (int i = 0; i < 3; i++) base[i] = acks_seen[i];
    grant_log.delete();
  endtask

  function automatic int log_at(input int i);
    return (grant_log.size() > i) ? grant_log[i] : -1;
  endfunction

  task automatic wait_idle(input string tag, input int max);
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 3 && n < max) begin
      step(1); n++;
      if (want[0] == 0 && want[1] == 0 && want[2] == 0 &&
          !r_req[0] && !r_req[1] && !r_req[2] && !busy && !mem_req) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_idle_in_time"}, 32'(quiet), 3);
  endtask

  task automatic wait_mreq(input string tag, input int max);
    int n;
    n = 0;
    while (!mem_req && n < max) begin
      step(1); n++;
    end
    check_eq({tag, "_mem_req_seen"}, 32'(mem_req), 1);
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    reset = 1'b1; pause = 1'b0;
    mem_lat = 0; fix_rdata = -1; spur_en = 1'b0; gap_max = 0;
    for (int i = 0; i < 3; i++) begin
      want[i] = 0; hold_next[i] = 0; use_fix[i] = 1'b0;
      fix_addr[i] = '0; fix_we[i] = 1'b0; fix_wd[i] = '0;
    end
    step(3);
    reset = 1'b0;
    step(2);

    // Single prg read with three cycles of controller latency.
    snap_base();
    use_fix[0] = 1'b1; fix_addr[0] = 23'h012345; mem_lat = 3; fix_rdata = 8'hA5;
    want[0] = 1;
    wait_idle("t1", 60);
    check_eq("t1_grants", 32'(grant_log.size()), 1);
    check_eq("t1_prg_acks", 32'(acks_seen[0] - base[0]), 1);
    check_eq("t1_rdata", 32'(rdata), 32'h0000_00A5);
    check_eq("t1_mem_addr", 32'(mem_addr), 32'h0001_2345);
    check_eq("t1_mem_we", 32'(mem_we), 0);
    check_eq("t1_busy", 32'(busy), 0);
    use_fix[0] = 1'b0; fix_rdata = -1;

    // All three at once, immediate mem_ack: prg, chr, aux in order.
    snap_base();
    mem_lat = 0;
    want[0] = 1; want[1] = 1; want[2] = 1;
    wait_idle("t2", 60);
    check_eq("t2_order0", 32'(log_at(0)), 0);
    check_eq("t2_order1", 32'(log_at(1)), 1);
    check_eq("t2_order2", 32'(log_at(2)), 2);
    for (int i = 0; i < 3; i++) check_eq("t2_acks", 32'(acks_seen[i] - base[i]), 1);

    // Continuous prg/chr traffic starves aux until the aging limit.
    snap_base();
    want[0] = 3; want[1] = 3; want[2] = 1;
    wait_idle("t3", 200);
    check_eq("t3_grants", 32'(grant_log.size()), 7);
    check_eq("t3_g0", 32'(log_at(0)), 0);
    check_eq("t3_g1", 32'(log_at(1)), 1);
    check_eq("t3_g2", 32'(log_at(2)), 0);
    check_eq("t3_g3", 32'(log_at(3)), 1);
    check_eq("t3_aux_promoted", 32'(log_at(4)), 2);

    // chr write with pause raised during ISSUE; pending aux waits for pause to drop.
    snap_base();
    use_fix[1] = 1'b1; fix_addr[1] = 23'h400010; fix_we[1] = 1'b1; fix_wd[1] = 8'h3C;
    mem_lat = 3;
    want[1] = 1;
    wait_mreq("t4", 20);
    pause = 1'b1;
    want[2] = 1;
    check_eq("t4_mem_addr", 32'(mem_addr), 32'h0040_0010);
    check_eq("t4_mem_we", 32'(mem_we), 1);
    check_eq("t4_mem_wdata", 32'(mem_wdata), 32'h3C);
    n = 0;
    while (acks_seen[1] == base[1] && n < 40) begin
      step(1); n++;
    end
    check_eq("t4_chr_ack", 32'(acks_seen[1] - base[1]), 1);
    step(6);
    check_eq("t4_aux_waiting", 32'(aux_req), 1);
    check_eq("t4_paused_mem_req", 32'(mem_req), 0);
    check_eq("t4_paused_busy", 32'(busy), 0);
    pause = 1'b0;
    step(1);
    check_eq("t4_aux_granted", 32'(mem_req), 1);
    check_eq("t4_aux_addr", 32'(mem_addr), 32'(r_addr[2]));
    wait_idle("t4", 60);
    check_eq("t4_aux_ack", 32'(acks_seen[2] - base[2]), 1);
    use_fix[1] = 1'b0;

    // Reset while in ISSUE abandons the access; a fresh request is served.
    snap_base();
    mem_lat = 5;
    want[0] = 1;
    wait_mreq("t5", 20);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("t5_mem_req", 32'(mem_req), 0);
    check_eq("t5_busy", 32'(busy), 0);
    step(4);
    check_eq("t5_no_ack", 32'(acks_seen[0] - base[0]), 0);
    mem_lat = 0;
    want[0] = 1;
    wait_idle("t5", 60);
    check_eq("t5_fresh_ack", 32'(acks_seen[0] - base[0]), 1);

    // prg holds req one cycle past its ack; chr must win the masked cycle.
    snap_base();
    hold_next[0] = 1;
    want[0] = 1; want[1] = 1;
    wait_idle("t6", 60);
    check_eq("t6_grants", 32'(grant_log.size()), 2);
    check_eq("t6_first", 32'(log_at(0)), 0);
    check_eq("t6_second", 32'(log_at(1)), 1);
    check_eq("t6_prg_once", 32'(acks_seen[0] - base[0]), 1);

    // Randomised traffic with random latency, pause and stray mem_ack pulses.
    snap_base();
    gap_max = 3; mem_lat = -1; spur_en = 1'b1;
    want[0] = 25; want[1] = 25; want[2] = 25;
    n = 0;
    while ((want[0] + want[1] + want[2]) > 0 && n < 4000) begin
      pause = ($urandom_range(0, 7) == 0);
      step(1); n++;
    end
    pause = 1'b0;
    spur_en = 1'b0;
    wait_idle("rnd", 200);
    for (int i = 0; i < 3; i++) check_eq("rnd_acks", 32'(acks_seen[i] - base[i]), 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
